// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/result handshake bundle for serial_subtractor; carries ovf when SERIAL_SUB_OVF_EN is defined
interface serial_subtractor_if #(parameter int WIDTH = 4);
    logic             in_valid, in_ready, bin, out_valid, out_ready, bout, busy;
    logic [WIDTH-1:0] a, b, diff;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
    modport master (output in_valid, a, b, bin, out_ready,
                    input in_ready, out_valid, diff, bout, busy, ovf);
    modport slave  (input in_valid, a, b, bin, out_ready,
                    output in_ready, out_valid, diff, bout, busy, ovf);
`else
    modport master (output in_valid, a, b, bin, out_ready,
                    input in_ready, out_valid, diff, bout, busy);
    modport slave  (input in_valid, a, b, bin, out_ready,
                    output in_ready, out_valid, diff, bout, busy);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one full-subtractor stage; SERIAL_SUB_OVF_EN adds signed overflow output
module serial_subtractor #(parameter int WIDTH = 4) (
    input logic             clk,
    input logic             rst_n,
    serial_subtractor_if.slave s
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] sa, sb, acc, diff;
    logic [CW-1:0]    cnt;
    logic             br, br_nx, d, bout, last, in_ready, out_valid, busy;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
    assign s.ovf = ovf;
`endif
    assign d     = sa[0] ^ sb[0] ^ br;
    assign br_nx = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    assign last  = cnt == CW'(WIDTH - 1);
    assign s.in_ready  = in_ready;
    assign s.out_valid = out_valid;
    assign s.busy      = busy;
    assign s.diff      = diff;
    assign s.bout      = bout;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (s.in_valid) state_n = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (s.out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    // diff/bout are only loaded on the final RUN edge so they keep the last result through IDLE and RUN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sa   <= '0;
            sb   <= '0;
            acc  <= '0;
            diff <= '0;
            cnt  <= '0;
            br   <= 1'b0;
            bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf  <= 1'b0;
`endif
        end else if (state == IDLE) begin
            if (s.in_valid) begin
                sa  <= s.a;
                sb  <= s.b;
                br  <= s.bin;
                cnt <= '0;
            end
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            br  <= br_nx;
            acc <= WIDTH'({d, acc} >> 1);
            cnt <= cnt + CW'(1);
            if (last) begin
                diff <= WIDTH'({d, acc} >> 1);
                bout <= br_nx;
`ifdef SERIAL_SUB_OVF_EN
                ovf  <= br ^ br_nx;
`endif
            end
        end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor against an arithmetic reference model
module tb_serial_subtractor;
    localparam int W = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    serial_subtractor_if #(.WIDTH(W)) bus();
    serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .s(bus.slave));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, b, input logic bin);
        int r;
        r = int'(a) - int'(b) - int'(bin);
        return r[W:0];
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] a, b, input logic bin);
        int sa, sb, r;
        sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
        sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
        r  = sa - sb - int'(bin);
        return (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
    endfunction

    task automatic run_op(input logic [W-1:0] a, b, input logic bin, input int hold);
        logic [W:0] exp;
        int busy_n, cyc;
        exp = model(a, b, bin);
        @(negedge clk);
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.bin = bin;
        @(negedge clk);
        bus.in_valid = 1'b0;
        busy_n = 0;
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            if (bus.busy) busy_n++;
            bus.in_valid  = 1'($urandom);
            bus.a         = W'($urandom);
            bus.out_ready = 1'($urandom);
            cyc++;
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        chk("out_valid", 32'(bus.out_valid), 32'd1);
        chk("busy_cycles", 32'(busy_n), 32'(W));
        chk("diff", 32'(bus.diff), 32'(exp[W-1:0]));
        chk("bout", 32'(bus.bout), 32'(exp[W]));
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", 32'(bus.ovf), 32'(model_ovf(a, b, bin)));
`endif
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'($urandom);
            bus.a        = W'($urandom);
            @(negedge clk);
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_ready", 32'(bus.in_ready), 32'd0);
            chk("hold_diff", 32'(bus.diff), 32'(exp[W-1:0]));
            chk("hold_bout", 32'(bus.bout), 32'(exp[W]));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("release_valid", 32'(bus.out_valid), 32'd0);
        chk("release_ready", 32'(bus.in_ready), 32'd1);
        chk("retain_diff", 32'(bus.diff), 32'(exp[W-1:0]));
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_diff", 32'(bus.diff), 32'd0);
        chk("rst_bout", 32'(bus.bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'b0011, 4'b0010, 1'b0, 2);
        // abort a computation mid-RUN
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = 4'b0110;
        bus.b = 4'b0001;
        bus.bin = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("mid_run_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_diff", 32'(bus.diff), 32'd0);
        chk("arst_bout", 32'(bus.bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'b0001, 4'b0010, 1'b0, 0);
        run_op(4'b0000, 4'b1111, 1'b1, 1);
        run_op(4'b1010, 4'b0101, 1'b1, 0);
        run_op(4'b1111, 4'b1111, 1'b0, 10);
        run_op(4'b1000, 4'b0001, 1'b0, 0);
        for (int i = 0; i < 30; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
